imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the non-pipelined 16-bit core. It accepts a framed byte stream (count, instruction words, checksum) on a valid/ready byte interface and writes the words into instruction memory from address 0. It holds the core in reset while loading, and releases it only after a clean checksum. It also watches the control unit's `holt` output so a halted core can be reloaded without a global reset.

## Interface

Parameters:
- `IMEM_SIZE`, 32, instruction memory depth in 16-bit words.
- `ADDR_W`, 5, instruction memory address width; `2**ADDR_W >= IMEM_SIZE`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_addr`  out  ADDR_W  instruction memory write address.
- `imem_wdata`  out  16  instruction memory write data.
- `imem_wr`  out  1  one-cycle write strobe.
- `core_rst_n`  out  1  active-low reset to the core (control unit, PC, register file).
- `core_holt`  in  1  halt indication from the control unit.
- `load_done`  out  1  image loaded and core running or halted.
- `load_err`  out  1  frame rejected.

## Operation

Frame format:
- Byte 0 is word count N, legal range 1..IMEM_SIZE.
- Then 2N bytes, high byte first per word.
- Then one checksum byte, equal to the XOR of byte 0 and all 2N payload bytes.

Byte transfer:
- A byte transfers on a rising edge with `rx_valid & rx_ready`.
- No transfer occurs otherwise; `rx_data` is ignored.

State machine:
- IDLE: `rx_ready`=1. On a transfer, latch N and set acc=byte and word index=0.
  - If N==0 or N>IMEM_SIZE, go to ERR.
  - Otherwise go to HI.
- HI: `rx_ready`=1. On a transfer, latch the high byte, XOR it into acc, go to LO.
- LO: `rx_ready`=1. On a transfer:
  - Register a write of {hi, byte} to address = index, and XOR the byte into acc.
  - Increment index; if the new index equals N go to CSUM, else go to HI.
- CSUM: `rx_ready`=1. On a transfer, go to RUN if byte==acc, else go to ERR.
- RUN: `rx_ready`=`core_holt`. A transfer while `core_holt`=1 is a new count byte and is handled exactly as in IDLE (go to HI or ERR).
- ERR: `rx_ready`=1. A transfer is a new count byte and is handled exactly as in IDLE.

Output decoding and width rules:
- `core_rst_n` = (state==RUN), `load_done` = (state==RUN), `load_err` = (state==ERR); all three are decoded from the state register.
- The index counter is `$clog2(IMEM_SIZE)+1` bits wide and never wraps. `imem_addr` is index[ADDR_W-1:0].
- Words already written before an ERR stay in memory. The core is never released on a rejected frame.
- Memory contents beyond N are untouched.

## Timing

Reset values (`rst_n` low):
- State IDLE, `rx_ready`=1.
- `imem_wr`=0, `imem_addr`=0, `imem_wdata`=0.
- `core_rst_n`=0, `load_done`=0, `load_err`=0.
- acc=0, index=0.

Reset mid-operation:
- Abandons the frame immediately and suppresses any pending `imem_wr`.
- The next byte is treated as a count byte.

Write timing:
- LO byte transferred at edge t: `imem_wr`=1 with valid addr/data for exactly one cycle, from t to t+1.
- Back-to-back bytes give at most one write every 2 cycles.

Core release:
- Checksum transferred at edge t: state is RUN and `core_rst_n`=1 from t.
- The last write (edge ≤ t-1) has already completed.
- Minimum frame duration is 2N+2 accepted bytes.

Reload:
- A count byte accepted in RUN at edge t drives `core_rst_n` to 0 from t. The core is held for the entire reload.
- In RUN with `core_holt`=0, `rx_ready`=0 and the stream is back-pressured indefinitely.

Flow control:
- Gaps in `rx_valid` in any state hold the state; no duplicate writes occur.

## Test plan

- Good frame, IMEM_SIZE=32: send 02 12 34 F0 00 D4 -> writes addr0=0x1234 then addr1=0xF000, one cycle each; RUN; `core_rst_n`=1 and `load_done`=1 on the edge accepting D4.
- Bad checksum: same frame ending D5 -> both writes occur; `load_err`=1; `core_rst_n` stays 0. Resend the good frame -> RUN.
- Illegal counts: count byte 00 -> ERR on that edge, no writes. Count byte 21 (33) -> ERR. Count byte 20 (32) followed by 64 bytes + correct checksum -> last write at addr 31, then RUN.
- Handshake gaps: random `rx_valid` deassertion of 0-5 cycles between every byte of the good frame -> identical writes, exactly 2 `imem_wr` pulses, RUN.
- Reload: in RUN with `core_holt`=0 and `rx_valid`=1 -> `rx_ready`=0, no change. Raise `core_holt` -> count byte accepted, `core_rst_n` falls on that edge; the new image is written from addr 0 and the core is released on a good checksum.
- Reset mid-frame: assert `rst_n` after byte 12 of the good frame -> all outputs return to reset values with no write. Resend the full frame -> addr0 written first.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory, core held in
// reset until the frame checksum matches; reloadable once the core halts.
module imem_loader #(
  parameter int IMEM_SIZE = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              imem_wr,
  output logic              core_rst_n,
  input  logic              core_holt,
  output logic              load_done,
  output logic              load_err
);

  localparam int IW = $clog2(IMEM_SIZE) + 1;
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0]        r_acc;
  logic [7:0]        w_acc_nx;
  logic [7:0]        r_hi;
  logic [7:0]        w_hi_nx;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nx;
  logic [IW-1:0]     r_n;
  logic [IW-1:0]     w_n_nx;
  logic              r_wr;
  logic              w_wr_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [15:0]       r_wdata;
  logic [15:0]       w_wdata_nx;

  logic              w_xfer;
  logic              w_cnt_ok;
  logic [IW-1:0]     w_idx_inc;

  // A running core only frees the stream once it has halted.
  assign rx_ready  = (r_state != S_RUN) | core_holt;
  assign w_xfer    = rx_valid & rx_ready;
  assign w_cnt_ok  = (rx_data != 8'd0) &&
                     (int'(rx_data) <= IMEM_SIZE);
  assign w_idx_inc = r_idx + ONE;

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_hi_nx    = r_hi;
    w_idx_nx   = r_idx;
    w_n_nx     = r_n;
    w_wr_nx    = 1'b0;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    unique case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (w_xfer) begin
          w_n_nx     = rx_data[IW-1:0];
          w_acc_nx   = rx_data;
          w_idx_nx   = '0;
          w_state_nx = w_cnt_ok ? S_HI : S_ERR;
        end
      end
      S_HI: begin
        if (w_xfer) begin
          w_hi_nx    = rx_data;
          w_acc_nx   = r_acc ^ rx_data;
          w_state_nx = S_LO;
        end
      end
      S_LO: begin
        if (w_xfer) begin
          w_wr_nx    = 1'b1;
          w_addr_nx  = r_idx[ADDR_W-1:0];
          w_wdata_nx = {r_hi, rx_data};
          w_acc_nx   = r_acc ^ rx_data;
          w_idx_nx   = w_idx_inc;
          w_state_nx = (w_idx_inc == r_n) ? S_CSUM : S_HI;
        end
      end
      S_CSUM: begin
        if (w_xfer)
          w_state_nx = (rx_data == r_acc) ? S_RUN : S_ERR;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_hi    <= '0;
      r_idx   <= '0;
      r_n     <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_hi    <= w_hi_nx;
      r_idx   <= w_idx_nx;
      r_n     <= w_n_nx;
      r_wr    <= w_wr_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
    end
  end

  assign imem_wr    = r_wr;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = (r_state == S_RUN);
  assign load_done  = (r_state == S_RUN);
  assign load_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random frames and gaps checked against a
// frame-level model of the loader.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_wr;
  logic        core_rst_n;
  logic        core_holt;
  logic        load_done;
  logic        load_err;

  imem_loader #(.IMEM_SIZE(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_wr    (imem_wr),
    .core_rst_n (core_rst_n),
    .core_holt  (core_holt),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [20:0] got_q[$];
  logic [20:0] exp_q[$];
  logic [7:0]  fb[$];
  logic [15:0] dut_mem[32];
  logic [15:0] exp_mem[32];
  bit          exp_run;

  initial begin
    for (int i = 0; i < 32; i++) begin
      dut_mem[i] = '0;
      exp_mem[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_wr === 1'b1) begin
      got_q.push_back({imem_addr, imem_wdata});
      dut_mem[imem_addr] <= imem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Frame semantics from the byte-level rules, independent of any FSM.
  task automatic model_frame();
    int n;
    logic [7:0] cs;
    exp_q.delete();
    n = int'(fb[0]);
    exp_run = 1'b0;
    if (n >= 1 && n <= 32) begin
      cs = fb[0];
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({5'(i), fb[1+2*i], fb[2+2*i]});
        exp_mem[i] = {fb[1+2*i], fb[2+2*i]};
        cs = cs ^ fb[1+2*i] ^ fb[2+2*i];
      end
      exp_run = (fb[2*n+1] == cs);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bit ok;
    rx_valid = 1'b0;
    repeat (gap) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (rx_ready === 1'b1) ok = 1'b1;
      else t++;
    end
    if (!ok) chk("handshake_timeout", 32'd1, 32'd0);
    else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] cs;
    fb.delete();
    fb.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < 2*n; i++) begin
      fb.push_back(8'($urandom));
      cs = cs ^ fb[fb.size()-1];
    end
    fb.push_back(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic send_frame(input string tag, input int maxgap);
    model_frame();
    got_q.delete();
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i == 0 && fb.size() > 1)
        chk({tag, "_hold"}, {31'd0, core_rst_n}, 32'd0);
    end
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_wr"}, {11'd0, got_q[i]}, {11'd0, exp_q[i]});
    chk({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_run});
    chk({tag, "_crst"}, {31'd0, core_rst_n}, {31'd0, exp_run});
    chk({tag, "_err"}, {31'd0, load_err}, {31'd0, !exp_run});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_wr"}, {31'd0, imem_wr}, 32'd0);
    chk({tag, "_addr"}, {27'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_crst"}, {31'd0, core_rst_n}, 32'd0);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  task automatic good_frame(input logic [7:0] last);
    fb.delete();
    fb.push_back(8'h02);
    fb.push_back(8'h12);
    fb.push_back(8'h34);
    fb.push_back(8'hF0);
    fb.push_back(8'h00);
    fb.push_back(last);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    core_holt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    good_frame(8'hD4);
    send_frame("good", 0);
    if (got_q.size() == 2) begin
      chk("good_w0", {11'd0, got_q[0]}, {11'd0, 5'd0, 16'h1234});
      chk("good_w1", {11'd0, got_q[1]}, {11'd0, 5'd1, 16'hF000});
    end else chk("good_wcount", got_q.size(), 32'd2);

    core_holt = 1'b1;
    good_frame(8'hD5);
    send_frame("badcs", 0);
    good_frame(8'hD4);
    send_frame("resend", 0);

    fb.delete();
    fb.push_back(8'h00);
    send_frame("cnt0", 0);
    fb.delete();
    fb.push_back(8'h21);
    send_frame("cnt33", 0);

    build(32, 1'b0);
    send_frame("cnt32", 0);
    if (got_q.size() > 0)
      chk("cnt32_last", {27'd0, got_q[got_q.size()-1][20:16]}, 32'd31);

    good_frame(8'hD4);
    send_frame("gaps", 5);

    core_holt = 1'b0;
    got_q.delete();
    rx_data  = 8'h03;
    rx_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_rdy", {31'd0, rx_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("bp_done", {31'd0, load_done}, 32'd1);
    chk("bp_nwr", got_q.size(), 32'd0);
    core_holt = 1'b1;
    build(int'($urandom_range(1, 8)), 1'b0);
    send_frame("reload", 2);

    for (int k = 0; k < 6; k++) begin
      build(int'($urandom_range(1, 12)), ($urandom_range(0, 2) == 0));
      send_frame("rand", 3);
    end

    for (int i = 0; i < 32; i++)
      chk("mem", {16'd0, dut_mem[i]}, {16'd0, exp_mem[i]});

    good_frame(8'hD4);
    got_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_nwr", got_q.size(), 32'd0);

    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rst_n = 1'b0;
    #1;
    chk("pendrst_wr", {31'd0, imem_wr}, 32'd0);
    chk("pendrst_addr", {27'd0, imem_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    good_frame(8'hD4);
    send_frame("after_rst", 1);
    if (got_q.size() > 0)
      chk("after_rst_a0", {27'd0, got_q[0][20:16]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
